lcd_msg_scheduler: RTL and testbench
====================================

Name: lcd_msg_scheduler

Overview:
- Shares one character LCD between NREQ message requesters (slot monitor, gate status, alarm, ...) using round-robin arbitration.
- For each granted request it sends a clear-display command, then exactly MSG_LEN characters.
- It then holds the message on screen for HOLD_CYC cycles before arbitrating again.
- Sits between the requesters and the byte-level LCD driver. The driver handles nibble splitting, E strobe and command execution time, and back-pressures through lcd_ready.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MSG_LEN, 12, characters per message (1..16).
- HOLD_CYC, 25000000, minimum display time in clk cycles after the last character is accepted; 0 means no hold.
- IDX_W, 4, width of rd_idx; must satisfy 2^IDX_W > MSG_LEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester message request (level).
- req_data  in  NREQ*8  per-requester character bus; slice i is requester i's char at rd_idx, valid combinationally in the same cycle.
- rd_idx  out  IDX_W  index of the character to be loaded next.
- gnt  out  NREQ  one-hot grant, held from arbitration to the end of HOLD.
- done  out  NREQ  one-cycle pulse on bit g when requester g's message is fully accepted.
- busy  out  1  high in every state except IDLE.
- lcd_valid  out  1  byte valid toward the driver.
- lcd_rs  out  1  0 = command, 1 = character.
- lcd_byte  out  8  command or character byte.
- lcd_ready  in  1  driver accepts the byte when lcd_valid and lcd_ready are both high at a clk edge.

Behaviour:
- All outputs are registered.
- Reset values: lcd_valid=0, lcd_rs=0, lcd_byte=0x00, gnt=0, done=0, busy=0, rd_idx=0, state=IDLE, rr pointer=NREQ-1 (so requester 0 wins first).
- Reset mid-transfer drops lcd_valid immediately. This is the only case where valid falls without a handshake.
- Handshake: once lcd_valid is high, lcd_valid, lcd_rs and lcd_byte stay stable until accepted.
- State IDLE, on an edge where req is non-zero:
  - grant the first set bit searching from pointer+1 modulo NREQ;
  - pointer <= granted index; gnt <= onehot(g);
  - lcd_valid<=1, lcd_rs<=0, lcd_byte<=0x01, rd_idx<=0;
  - go to CLR.
  - Latency: req high → lcd_valid high 1 cycle later.
- State CLR, on handshake:
  - lcd_rs<=1, lcd_byte<=req_data[g][rd_idx=0], rd_idx<=1;
  - go to CHAR. There is no bubble and lcd_valid stays high.
- State CHAR, on handshake with rd_idx<MSG_LEN:
  - lcd_byte<=req_data[g][rd_idx], rd_idx<=rd_idx+1.
- State CHAR, on handshake with rd_idx==MSG_LEN (last char accepted):
  - lcd_valid<=0, done[g]<=1 for one cycle;
  - go to HOLD, or to IDLE if HOLD_CYC==0.
- State HOLD: counts HOLD_CYC cycles, then goes to IDLE. gnt is cleared when entering IDLE; busy falls in the same cycle.
- req is sampled only in IDLE:
  - dropping req mid-message does not abort the message;
  - a new request during busy waits for IDLE.
- Simultaneous requests are resolved round-robin. A requester holding req continuously cannot starve others: with all req high, grants rotate 0,1,2,0,...
- lcd_ready may be high while lcd_valid is low; this has no effect.
- A stall of any length in any state holds all outputs.
- Character data is captured at load time. Changes to req_data after loading do not affect the byte already presented.

Decomposition:
- Package lcd_sched_pkg holds:
  - state enum {IDLE, CLR, CHAR, HOLD};
  - LCD_CMD_CLEAR=8'h01;
  - LCD_RS_CMD=1'b0, LCD_RS_DATA=1'b1.
- Sub-module rr_arbiter (NREQ): combinational round-robin pick from req and pointer, returning a one-hot and an index. This is instantiated once; the pointer register stays in the scheduler.

Test Plan (NREQ=3, MSG_LEN=4, HOLD_CYC=8, lcd_ready=1 unless stated):
- Single request: req=3'b001 with requester 0 supplying "SLOT" → byte stream 0x01(rs0), 0x53, 0x4C, 0x4F, 0x54(rs1) on consecutive cycles. done=001 the cycle after 0x54 is accepted. busy stays high 8 more cycles, then gnt=0.
- All requesters constant high (req=3'b111) for 3 messages → gnt sequence 001, 010, 100, and each message is preceded by a 0x01 command.
- Back-pressure: lcd_ready low 5 cycles while 0x4C is presented → lcd_byte stays 0x4C and lcd_valid stays 1. Accepted count is exactly 5 bytes; no byte is skipped or duplicated.
- Request drop: req[0] falls after the clear is accepted → all 4 chars are still sent and done[0] pulses. Requester 1 raised at the same time is granted only after HOLD expires.
- rst asserted mid-CHAR (after 2 chars) → next cycle lcd_valid=0, gnt=0, busy=0. With req=3'b011 afterwards, requester 0 is granted first.
- HOLD_CYC=0 build: with req held high, the next 0x01 appears 2 cycles after the last char is accepted (one IDLE cycle, then valid). done pulses exactly once per message.

Source files
------------

// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD message scheduler.
package lcd_sched_pkg;

  typedef enum logic [1:0] {IDLE, CLR, CHAR, HOLD} state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic       LCD_RS_CMD    = 1'b0;
  localparam logic       LCD_RS_DATA   = 1'b1;

endpackage

// File: rtl/lcd_msg_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IW-1:0]   gnt_idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        gnt_oh[cand]  = 1'b1;
        gnt_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Round-robin scheduler sharing one character LCD: clear, MSG_LEN chars, hold, repeat.
module lcd_msg_scheduler #(
  parameter int NREQ     = 3,
  parameter int MSG_LEN  = 12,
  parameter int HOLD_CYC = 25000000,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  output logic [IDX_W-1:0]  rd_idx,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              lcd_valid,
  output logic              lcd_rs,
  output logic [7:0]        lcd_byte,
  input  logic              lcd_ready
);

  import lcd_sched_pkg::*;

  localparam int IW     = $clog2(NREQ);
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MSG_LEN);

  state_t            state_q, state_n;
  logic [IW-1:0]     ptr_q, ptr_n;
  logic [IW-1:0]     g_q, g_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic [NREQ-1:0]   gnt_n, done_n;
  logic              busy_n, valid_n, rs_n;
  logic [7:0]        byte_n;
  logic [IDX_W-1:0]  idx_n;

  logic [NREQ-1:0]   arb_oh;
  logic [IW-1:0]     arb_idx;
  logic [7:0]        cur_char;
  logic              hs;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  assign cur_char = req_data[int'(g_q)*8 +: 8];
  assign hs       = lcd_valid && lcd_ready;

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    g_n     = g_q;
    hold_n  = hold_q;
    gnt_n   = gnt;
    done_n  = '0;
    valid_n = lcd_valid;
    rs_n    = lcd_rs;
    byte_n  = lcd_byte;
    idx_n   = rd_idx;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_n = CLR;
          ptr_n   = arb_idx;
          g_n     = arb_idx;
          gnt_n   = arb_oh;
          valid_n = 1'b1;
          rs_n    = LCD_RS_CMD;
          byte_n  = LCD_CMD_CLEAR;
          idx_n   = '0;
        end
      end
      CLR: begin
        if (hs) begin
          state_n = CHAR;
          rs_n    = LCD_RS_DATA;
          byte_n  = cur_char;
          idx_n   = rd_idx + 1'b1;
        end
      end
      CHAR: begin
        if (hs) begin
          if (rd_idx == LAST_IDX) begin
            valid_n     = 1'b0;
            done_n[g_q] = 1'b1;
            if (HOLD_CYC == 0) begin
              state_n = IDLE;
              gnt_n   = '0;
            end else begin
              state_n = HOLD;
              hold_n  = HOLD_LAST;
            end
          end else begin
            byte_n = cur_char;
            idx_n  = rd_idx + 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_n = IDLE;
          gnt_n   = '0;
        end else begin
          hold_n = hold_q - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Every output is a register; reset drops lcd_valid without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NREQ - 1);
      g_q       <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      lcd_valid <= 1'b0;
      lcd_rs    <= LCD_RS_CMD;
      lcd_byte  <= 8'h00;
      rd_idx    <= '0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      g_q       <= g_n;
      hold_q    <= hold_n;
      gnt       <= gnt_n;
      done      <= done_n;
      busy      <= busy_n;
      lcd_valid <= valid_n;
      lcd_rs    <= rs_n;
      lcd_byte  <= byte_n;
      rd_idx    <= idx_n;
    end
  end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Directed bench: a HOLD_CYC=8 instance and a HOLD_CYC=0 instance, 3 requesters, 4-char messages.
module tb_lcd_msg_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, req_b;
  logic [23:0] req_data, req_data_b;
  logic [3:0]  rd_idx, rd_idx_b;
  logic [2:0]  gnt, gnt_b, done, done_b;
  logic        busy, busy_b;
  logic        lcd_valid, lcd_valid_b, lcd_rs, lcd_rs_b;
  logic [7:0]  lcd_byte, lcd_byte_b;
  logic        lcd_ready;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt_b = 0;
  logic [8:0] acc_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] msg_char(input int r, input int k);
    string s;
    case (r)
      0:       s = "SLOT";
      1:       s = "GATE";
      default: s = "ALRM";
    endcase
    if (k < 0 || k > 3) return 8'h00;
    return s[k];
  endfunction

  function automatic logic [31:0] oh(input int r);
    return 32'(1) << r;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_data
    assign req_data[i*8 +: 8]   = msg_char(i, int'(rd_idx));
    assign req_data_b[i*8 +: 8] = msg_char(i, int'(rd_idx_b));
  end

  lcd_msg_scheduler #(.NREQ(3), .MSG_LEN(4), .HOLD_CYC(8), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .rd_idx(rd_idx),
    .gnt(gnt), .done(done), .busy(busy), .lcd_valid(lcd_valid), .lcd_rs(lcd_rs),
    .lcd_byte(lcd_byte), .lcd_ready(lcd_ready)
  );

  lcd_msg_scheduler #(.NREQ(3), .MSG_LEN(4), .HOLD_CYC(0), .IDX_W(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_data(req_data_b), .rd_idx(rd_idx_b),
    .gnt(gnt_b), .done(done_b), .busy(busy_b), .lcd_valid(lcd_valid_b), .lcd_rs(lcd_rs_b),
    .lcd_byte(lcd_byte_b), .lcd_ready(lcd_ready)
  );

  always @(posedge clk) begin
    if (!rst && lcd_valid && lcd_ready) acc_q.push_back({lcd_rs, lcd_byte});
    if (!rst && (|done_b)) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid_a(input int bound);
    int n = 0;
    while (!lcd_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!lcd_valid) check("timeout_valid", 32'(lcd_valid), 1);
  endtask

  // One full message on the HOLD_CYC=8 instance; req_after is applied once the clear is accepted.
  task automatic run_msg(input int r, input logic [2:0] req_after, input int stall_k, input int stall_n);
    wait_valid_a(40);
    acc_q.delete();
    check("clr_valid", 32'(lcd_valid), 1);
    check("clr_rs",    32'(lcd_rs), 0);
    check("clr_byte",  32'(lcd_byte), 32'h01);
    check("gnt",       32'(gnt), oh(r));
    check("busy",      32'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) req = req_after;
      check("chr_rs",   32'(lcd_rs), 1);
      check("chr_byte", 32'(lcd_byte), 32'(msg_char(r, k)));
      if (k == stall_k) begin
        lcd_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          check("stall_valid", 32'(lcd_valid), 1);
          check("stall_byte",  32'(lcd_byte), 32'(msg_char(r, k)));
        end
        lcd_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("done",      32'(done), oh(r));
    check("end_valid", 32'(lcd_valid), 0);
    check("acc_count", 32'(acc_q.size()), 5);
    if (acc_q.size() == 5) begin
      check("acc_clr", 32'(acc_q[0]), 32'h001);
      for (int k = 0; k < 4; k++)
        check("acc_chr", 32'(acc_q[k+1]), {23'd0, 1'b1, msg_char(r, k)});
    end
    repeat (7) begin
      @(negedge clk);
      check("hold_busy", 32'(busy), 1);
      check("hold_gnt",  32'(gnt), oh(r));
      check("hold_done", 32'(done), 0);
    end
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_gnt",  32'(gnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 3'b000; req_b = 3'b000; lcd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(lcd_valid), 0);
    check("rst_rs",    32'(lcd_rs), 0);
    check("rst_byte",  32'(lcd_byte), 0);
    check("rst_gnt",   32'(gnt), 0);
    check("rst_done",  32'(done), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_idx",   32'(rd_idx), 0);
    rst = 1'b0;

    // single request "SLOT"
    req = 3'b001;
    @(negedge clk);
    run_msg(0, 3'b000, -1, 0);

    // all requesters high: grants rotate 0,1,2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 3'b111;
    run_msg(0, 3'b111, -1, 0);
    run_msg(1, 3'b111, -1, 0);
    run_msg(2, 3'b000, -1, 0);

    // back-pressure for 5 cycles while 'L' is presented
    req = 3'b001;
    run_msg(0, 3'b000, 1, 5);

    // req[0] drops and req[1] rises after the clear is accepted
    req = 3'b001;
    run_msg(0, 3'b010, -1, 0);
    run_msg(1, 3'b000, -1, 0);

    // reset after two characters accepted
    req = 3'b001;
    wait_valid_a(40);
    repeat (3) @(negedge clk);
    check("pre_rst_byte", 32'(lcd_byte), 32'h4F);
    rst = 1'b1;
    req = 3'b011;
    @(negedge clk);
    check("mid_rst_valid", 32'(lcd_valid), 0);
    check("mid_rst_gnt",   32'(gnt), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_idx",   32'(rd_idx), 0);
    rst = 1'b0;
    run_msg(0, 3'b000, -1, 0);

    // HOLD_CYC=0 instance: next clear two cycles after the last char
    req_b = 3'b111;
    for (int m = 0; m < 2; m++) begin
      int n = 0;
      while (!lcd_valid_b && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("b_clr_byte", 32'(lcd_byte_b), 32'h01);
      check("b_gnt",      32'(gnt_b), oh(m));
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("b_chr_byte", 32'(lcd_byte_b), 32'(msg_char(m, k)));
      end
      @(negedge clk);
      check("b_done",  32'(done_b), oh(m));
      check("b_valid", 32'(lcd_valid_b), 0);
      check("b_busy",  32'(busy_b), 0);
      @(negedge clk);
      check("b_next_valid", 32'(lcd_valid_b), 1);
      check("b_next_byte",  32'(lcd_byte_b), 32'h01);
      check("b_next_done",  32'(done_b), 0);
      check("b_done_cnt",   32'(done_cnt_b), 32'(m + 1));
    end
    req_b = 3'b000;
    repeat (10) @(negedge clk);
    check("b_done_total", 32'(done_cnt_b), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
